// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one WIDTH-bit word per START, MSB first.
// Each SCLK half-period and the setup/hold phases last CLKDIV clocks.
module spi_master_ctrl #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_txdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rxdata,
  output logic             o_sclk,
  output logic             o_cs,
  output logic             o_mosi,
  input  logic             i_miso
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [7:0] TLOAD = 8'(CLKDIV - 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIGH,
    S_SLOW,
    S_HOLD,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [7:0]       r_timer;
  logic [CW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_rxdata;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_cs;
  logic             r_mosi;

  logic [WIDTH-1:0] w_tx_next;
  logic [WIDTH-1:0] w_rx_next;
  logic             w_tick;

  assign w_tx_next = r_tx << 1;
  assign w_rx_next = (r_rx << 1) | WIDTH'(i_miso);
  assign w_tick    = (r_timer == 8'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rxdata <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_cs     <= 1'b1;
      r_mosi   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_SETUP;
            r_tx     <= i_txdata;
            r_rx     <= '0;
            r_bitcnt <= '0;
            r_timer  <= TLOAD;
            r_cs     <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= i_txdata[WIDTH-1];
            r_busy   <= 1'b1;
          end
        end
        S_SETUP, S_SLOW: begin
          if (w_tick) begin
            r_state <= S_SHIGH;
            r_timer <= TLOAD;
            r_sclk  <= 1'b1;
            r_rx    <= w_rx_next;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_SHIGH: begin
          if (w_tick) begin
            r_timer  <= TLOAD;
            r_sclk   <= 1'b0;
            r_bitcnt <= r_bitcnt + 1'b1;
            // The low half-period after the last bit doubles as the hold
            if (r_bitcnt == LAST) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_SLOW;
              r_tx    <= w_tx_next;
              r_mosi  <= w_tx_next[WIDTH-1];
            end
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_state  <= S_FINISH;
            r_cs     <= 1'b1;
            r_mosi   <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_rxdata <= r_rx;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_rxdata = r_rxdata;
  assign o_sclk   = r_sclk;
  assign o_cs     = r_cs;
  assign o_mosi   = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: offset-based waveform model plus directed
// and randomized transfers, with a second CLKDIV=1 instance.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int W = 8;
  localparam int P = 4;
  localparam int L = P * (2 * W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] txd = '0;
  logic         busy, done, sclk, cs, mosi, miso;
  logic [W-1:0] rxd;
  int           mode = 0;
  logic         miso_rnd = 1'b0;

  assign miso = (mode == 1) ? mosi : (mode == 2) ? 1'b1 : miso_rnd;

  always @(negedge clk) miso_rnd <= 1'($urandom);

  spi_master_ctrl #(.WIDTH(W), .CLKDIV(P)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_txdata(txd),
    .o_busy(busy), .o_done(done), .o_rxdata(rxd), .o_sclk(sclk),
    .o_cs(cs), .o_mosi(mosi), .i_miso(miso)
  );

  logic         start1 = 1'b0;
  logic [W-1:0] txd1 = '0;
  logic         busy1, done1, sclk1, cs1, mosi1;
  logic [W-1:0] rxd1;

  spi_master_ctrl #(.WIDTH(W), .CLKDIV(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_txdata(txd1),
    .o_busy(busy1), .o_done(done1), .o_rxdata(rxd1), .o_sclk(sclk1),
    .o_cs(cs1), .o_mosi(mosi1), .i_miso(mosi1)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 transferring (m_t clocks since accept), 2 finish
  int           m_ph;
  int           m_t;
  logic [W-1:0] m_tx, m_acc, m_rx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_t <= 0; m_tx <= '0; m_acc <= '0; m_rx <= '0;
    end else begin
      case (m_ph)
        0: if (start) begin
          m_ph <= 1; m_t <= 0; m_tx <= txd; m_acc <= '0;
        end
        1: if (m_t == L - 1) begin
          m_ph <= 2; m_rx <= m_acc;
        end else begin
          m_t <= m_t + 1;
          if ((m_t + 1) % (2 * P) == P) m_acc <= {m_acc[W-2:0], miso};
        end
        default: m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int ph, bi;
    logic e_cs, e_sclk, e_mosi, e_busy, e_done;
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (!rst && m_ph == 1) begin
      ph = m_t / P;
      bi = ph / 2;
      if (bi > W - 1) bi = W - 1;
      e_cs = 1'b0;
      e_sclk = ph[0];
      e_mosi = m_tx[W-1-bi];
      e_busy = 1'b1;
    end else if (!rst && m_ph == 2) begin
      e_done = 1'b1;
    end
    chk("cs", cs, e_cs);
    chk("sclk", sclk, e_sclk);
    chk("mosi", mosi, e_mosi);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("rxdata", rxd, rst ? '0 : m_rx);
  end

  int           r_cyc, r_cslow, r_rises;
  logic [W-1:0] r_mbits;
  logic         r_mosi_hi;

  task automatic xfer(input logic [W-1:0] d, input int poke_at);
    logic prev;
    @(negedge clk);
    start = 1'b1; txd = d;
    @(posedge clk);
    r_cyc = 0; r_cslow = 0; r_rises = 0; r_mbits = '0; r_mosi_hi = 1'b0;
    prev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      r_cyc++;
      if (r_cyc == 1) begin start = 1'b0; txd = W'($urandom); end
      if (poke_at > 0 && r_cyc == poke_at) begin start = 1'b1; txd = 8'h3C; end
      if (poke_at > 0 && r_cyc == poke_at + 1) start = 1'b0;
      if (!cs) r_cslow++;
      if (sclk && !prev) begin r_rises++; r_mbits = {r_mbits[W-2:0], mosi}; end
      prev = sclk;
      if (mosi) r_mosi_hi = 1'b1;
      if (done) break;
    end
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nd, gap, dcnt, t1, t2, cyc, spc_bad, last_rise;
    logic [W-1:0] rx_a, rx_b;
    logic prev;

    repeat (3) @(negedge clk);
    chk("reset_cs", cs, 1'b1);
    chk("reset_rx", rxd, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 1;
    xfer(8'hA5, 0);
    chk("a5_latency", r_cyc, 69);
    chk("a5_rx", rxd, 8'hA5);
    chk("a5_rises", r_rises, 8);
    chk("a5_mosi_bits", r_mbits, 8'hA5);
    chk("a5_cslow", r_cslow, 68);

    mode = 2;
    repeat (2) @(negedge clk);
    xfer(8'h00, 0);
    chk("ff_rx", rxd, 8'hFF);
    chk("ff_mosi_hi", r_mosi_hi, 1'b0);
    chk("ff_rises", r_rises, 8);
    chk("ff_cslow", r_cslow, 68);

    mode = 1;
    repeat (2) @(negedge clk);
    xfer(8'h96, 10);
    chk("poke_rx", rxd, 8'h96);
    count_dones(100, dcnt);
    chk("poke_extra_done", dcnt, 0);

    @(negedge clk);
    start = 1'b1; txd = 8'h77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_cs_now", cs, 1'b1);
    chk("rst_sclk_now", sclk, 1'b0);
    chk("rst_busy_now", busy, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 chk("start_in_reset", busy, 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    count_dones(100, dcnt);
    chk("rst_no_done", dcnt, 0);
    chk("rst_rx", rxd, 8'h00);
    xfer(8'h5A, 0);
    chk("after_rst_rx", rxd, 8'h5A);

    repeat (2) @(negedge clk);
    start = 1'b1; txd = 8'h81;
    @(posedge clk);
    @(negedge clk);
    txd = 8'h7E;
    nd = 0; gap = 0; t1 = 0; t2 = 0; cyc = 0; rx_a = '0; rx_b = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (nd == 0) begin t1 = cyc; rx_a = rxd; end
        else begin t2 = cyc; rx_b = rxd; end
        nd++;
      end
      if (nd == 1 && cs) gap++;
      if (nd == 2) break;
    end
    start = 1'b0;
    chk("b2b_dones", nd, 2);
    chk("b2b_spacing", t2 - t1, L + 2);
    chk("b2b_gap", gap, 2);
    chk("b2b_rx1", rx_a, 8'h81);
    chk("b2b_rx2", rx_b, 8'h7E);

    for (int k = 0; k < 25; k++) begin
      mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      xfer(W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 60)) : 0);
    end
    repeat (3) @(negedge clk);

    @(negedge clk);
    start1 = 1'b1; txd1 = 8'hC3;
    @(posedge clk);
    cyc = 0; gap = 0; nd = 0; spc_bad = 0; last_rise = 0; prev = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin start1 = 1'b0; txd1 = 8'h00; end
      if (!cs1) gap++;
      if (sclk1 && !prev) begin
        if (nd > 0 && cyc - last_rise != 2) spc_bad++;
        last_rise = cyc;
        nd++;
      end
      prev = sclk1;
      if (done1) break;
    end
    chk("d1_done", done1, 1'b1);
    chk("d1_latency", cyc, 18);
    chk("d1_cslow", gap, 17);
    chk("d1_rises", nd, 8);
    chk("d1_period", spc_bad, 0);
    chk("d1_rx", rxd1, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
